// File: rtl/atm_pkg.sv
// Shared types for the ATM transaction controller: state and error encodings,
// transaction mode constants.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PIN    = 3'd1,
        ST_MODE   = 3'd2,
        ST_AMOUNT = 3'd3,
        ST_FACE   = 3'd4,
        ST_COMMIT = 3'd5,
        ST_STMT   = 3'd6,
        ST_LOCKED = 3'd7
    } atm_state_e;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BAD_PIN  = 3'd1,
        ERR_LOCKED   = 3'd2,
        ERR_INSUFF   = 3'd3,
        ERR_LIMIT    = 3'd4,
        ERR_OVERFLOW = 3'd5,
        ERR_TIMEOUT  = 3'd6,
        ERR_CARD_OUT = 3'd7
    } atm_err_e;

    localparam logic MODE_WITHDRAW = 1'b0;
    localparam logic MODE_DEPOSIT  = 1'b1;

    // States in which the session idle timer is allowed to abort the session
    function automatic logic is_wait_state(input atm_state_e s);
        return s inside {ST_PIN, ST_MODE, ST_AMOUNT, ST_FACE, ST_STMT};
    endfunction

endpackage

// File: rtl/atm_txn_ctrl_if.sv
// Front-end/account-store bundle for atm_txn_ctrl: master drives the strobes
// and account data, slave (the controller) drives the status outputs.
interface atm_txn_ctrl_if #(
    parameter int unsigned PIN_W = 4,
    parameter int unsigned AMT_W = 8,
    parameter int unsigned BAL_W = 16,
    parameter int unsigned ATT_W = 2
);
    logic             card_in;
    logic [PIN_W-1:0] ref_pin;
    logic [BAL_W-1:0] bal_in;
    logic             pin_valid;
    logic [PIN_W-1:0] pin_data;
    logic             mode_valid;
    logic             mode;
    logic             amt_valid;
    logic [AMT_W-1:0] amount;
    logic             face_ok;
    logic             face_fail;
    logic             confirm;
    logic             cancel;

    logic [2:0]       state_o;
    logic [BAL_W-1:0] balance_o;
    logic [ATT_W-1:0] attempts_left;
    logic             pin_locked;
    logic             txn_done;
    logic             err_valid;
    logic [2:0]       err_code;

    modport master (
        output card_in, ref_pin, bal_in, pin_valid, pin_data, mode_valid, mode,
               amt_valid, amount, face_ok, face_fail, confirm, cancel,
        input  state_o, balance_o, attempts_left, pin_locked, txn_done,
               err_valid, err_code
    );

    modport slave (
        input  card_in, ref_pin, bal_in, pin_valid, pin_data, mode_valid, mode,
               amt_valid, amount, face_ok, face_fail, confirm, cancel,
        output state_o, balance_o, attempts_left, pin_locked, txn_done,
               err_valid, err_code
    );
endinterface

// File: rtl/atm_cycle_timer.sv
// Loadable down-counter: load sets LEN, clear zeroes, otherwise counts to 0.
// expire is high during the final counted cycle, idle once the count is spent.
module atm_cycle_timer #(
    parameter int unsigned LEN = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic expire,
    output logic idle
);
    localparam int unsigned W = $clog2(LEN + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(LEN);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == W'(1));
    assign idle   = (cnt == '0);
endmodule

// File: rtl/atm_txn_ctrl.sv
// ATM session/transaction controller. Define ATM_FACE_AUTH_EN to build the
// biometric step-up (FACE) path for withdrawals above WD_LIMIT.
module atm_txn_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned PIN_W        = 4,
    parameter int unsigned AMT_W        = 8,
    parameter int unsigned BAL_W        = 16,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned WD_LIMIT     = 10,
    parameter int unsigned DEP_MAX      = 10,
    parameter int unsigned LOCK_CYC     = 64,
    parameter int unsigned TIMEOUT_CYC  = 32
) (
    input  logic          clk,
    input  logic          reset,
    atm_txn_ctrl_if.slave bus
);
    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

    atm_state_e       state_q, state_n;
    logic [BAL_W-1:0] balance_q, balance_n;
    logic [ATT_W-1:0] att_q, att_n;
    logic             mode_q, mode_n;
    logic [AMT_W-1:0] amt_q, amt_n;
    logic             txn_done_q, txn_n;
    logic             err_valid_q, errv_n;
    atm_err_e         err_code_q, errc_n;
    logic             accepted;

    logic             to_expire, unused_to_idle;
    logic             lk_expire, lk_idle;

    logic [BAL_W-1:0] amt_in_ext, amt_q_ext;
    logic [BAL_W:0]   dep_sum;

    assign amt_in_ext = BAL_W'(bus.amount);
    assign amt_q_ext  = BAL_W'(amt_q);
    assign dep_sum    = {1'b0, balance_q} + {1'b0, amt_in_ext};

`ifndef ATM_FACE_AUTH_EN
    logic unused_face;
    assign unused_face = bus.face_ok ^ bus.face_fail;
`endif

    // Priority: card removal, then idle timeout, then the state's own strobes
    always_comb begin
        state_n   = state_q;
        balance_n = balance_q;
        att_n     = att_q;
        mode_n    = mode_q;
        amt_n     = amt_q;
        txn_n     = 1'b0;
        errv_n    = 1'b0;
        errc_n    = err_code_q;
        accepted  = 1'b0;
        if (state_q != ST_IDLE && state_q != ST_LOCKED && !bus.card_in) begin
            state_n = ST_IDLE;
            if (state_q != ST_STMT) begin
                errv_n = 1'b1;
                errc_n = ERR_CARD_OUT;
            end
        end else if (is_wait_state(state_q) && to_expire) begin
            state_n = ST_IDLE;
            errv_n  = 1'b1;
            errc_n  = ERR_TIMEOUT;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.card_in) begin
                    state_n   = ST_PIN;
                    balance_n = bus.bal_in;
                    att_n     = ATT_W'(MAX_ATTEMPTS);
                    errc_n    = ERR_NONE;
                end
                ST_PIN: if (bus.pin_valid) begin
                    accepted = 1'b1;
                    if (bus.pin_data == bus.ref_pin) begin
                        state_n = ST_MODE;
                    end else if (att_q <= ATT_W'(1)) begin
                        att_n   = '0;
                        state_n = ST_LOCKED;
                        errv_n  = 1'b1;
                        errc_n  = ERR_LOCKED;
                    end else begin
                        att_n  = att_q - 1'b1;
                        errv_n = 1'b1;
                        errc_n = ERR_BAD_PIN;
                    end
                end
                ST_MODE: if (bus.mode_valid) begin
                    accepted = 1'b1;
                    mode_n   = bus.mode;
                    state_n  = ST_AMOUNT;
                end
                ST_AMOUNT: if (bus.amt_valid && bus.amount != '0) begin
                    accepted = 1'b1;
                    amt_n    = bus.amount;
                    state_n  = ST_COMMIT;
                    if (mode_q == MODE_WITHDRAW) begin
                        if (amt_in_ext > balance_q) begin
                            state_n = ST_MODE;
                            errv_n  = 1'b1;
                            errc_n  = ERR_INSUFF;
                        end else if (32'(bus.amount) > WD_LIMIT) begin
`ifdef ATM_FACE_AUTH_EN
                            state_n = ST_FACE;
`else
                            state_n = ST_MODE;
                            errv_n  = 1'b1;
                            errc_n  = ERR_LIMIT;
`endif
                        end
                    end else if (32'(bus.amount) > DEP_MAX) begin
                        state_n = ST_MODE;
                        errv_n  = 1'b1;
                        errc_n  = ERR_LIMIT;
                    end else if (dep_sum[BAL_W]) begin
                        state_n = ST_MODE;
                        errv_n  = 1'b1;
                        errc_n  = ERR_OVERFLOW;
                    end
                end
`ifdef ATM_FACE_AUTH_EN
                ST_FACE: if (bus.face_ok) begin
                    accepted = 1'b1;
                    state_n  = ST_COMMIT;
                end else if (bus.face_fail) begin
                    accepted = 1'b1;
                    state_n  = ST_AMOUNT;
                end
`endif
                ST_COMMIT: begin
                    balance_n = (mode_q == MODE_DEPOSIT) ? balance_q + amt_q_ext
                                                         : balance_q - amt_q_ext;
                    txn_n     = 1'b1;
                    state_n   = ST_STMT;
                end
                ST_STMT: if (bus.confirm) begin
                    accepted = 1'b1;
                    state_n  = ST_MODE;
                end else if (bus.cancel) begin
                    accepted = 1'b1;
                    state_n  = ST_IDLE;
                end
                ST_LOCKED: if ((lk_expire || lk_idle) && !bus.card_in) begin
                    state_n = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    atm_cycle_timer #(.LEN(TIMEOUT_CYC)) u_session_timer (
        .clk    (clk),
        .reset  (reset),
        .load   ((state_n != state_q) || accepted),
        .clear  (state_n == ST_IDLE),
        .expire (to_expire),
        .idle   (unused_to_idle)
    );

    atm_cycle_timer #(.LEN(LOCK_CYC)) u_lock_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (state_n == ST_LOCKED && state_q != ST_LOCKED),
        .clear  (1'b0),
        .expire (lk_expire),
        .idle   (lk_idle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            balance_q   <= '0;
            att_q       <= '0;
            mode_q      <= MODE_WITHDRAW;
            amt_q       <= '0;
            txn_done_q  <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_n;
            balance_q   <= balance_n;
            att_q       <= att_n;
            mode_q      <= mode_n;
            amt_q       <= amt_n;
            txn_done_q  <= txn_n;
            err_valid_q <= errv_n;
            err_code_q  <= errc_n;
        end
    end

    assign bus.state_o       = state_q;
    assign bus.balance_o     = balance_q;
    assign bus.attempts_left = att_q;
    assign bus.pin_locked    = (state_q == ST_LOCKED);
    assign bus.txn_done      = txn_done_q;
    assign bus.err_valid     = err_valid_q;
    assign bus.err_code      = err_code_q;
endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Testbench for atm_txn_ctrl: directed vector table, hand-written corner
// sequences, then randomized traffic against a behavioural session model.
module tb_atm_txn_ctrl;
    localparam int unsigned PIN_W = 4, AMT_W = 8, BAL_W = 16;
    localparam int unsigned MAX_ATTEMPTS = 3, WD_LIMIT = 10, DEP_MAX = 10;
    localparam int unsigned LOCK_CYC = 64, TIMEOUT_CYC = 32;
    localparam int unsigned ATT_W = $clog2(MAX_ATTEMPTS + 1);

    localparam int S_IDLE = 0, S_PIN = 1, S_MODE = 2, S_AMOUNT = 3;
    localparam int S_FACE = 4, S_COMMIT = 5, S_STMT = 6, S_LOCKED = 7;
    localparam int E_NONE = 0, E_BAD_PIN = 1, E_LOCKED = 2, E_INSUFF = 3;
    localparam int E_LIMIT = 4, E_OVERFLOW = 5, E_TIMEOUT = 6, E_CARD_OUT = 7;

    logic clk = 1'b0;
    logic reset;

    atm_txn_ctrl_if #(.PIN_W(PIN_W), .AMT_W(AMT_W), .BAL_W(BAL_W), .ATT_W(ATT_W)) bus ();

    atm_txn_ctrl #(
        .PIN_W(PIN_W), .AMT_W(AMT_W), .BAL_W(BAL_W), .MAX_ATTEMPTS(MAX_ATTEMPTS),
        .WD_LIMIT(WD_LIMIT), .DEP_MAX(DEP_MAX), .LOCK_CYC(LOCK_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef enum int {K_NONE, K_PIN, K_MODE, K_AMT, K_FOK, K_FFAIL, K_CONF, K_CANC} kind_e;

    typedef struct {
        bit    card;
        kind_e kind;
        int    val;
        int    st;
        int    bal;
        bit    ev;
        int    ec;
        bit    done;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit card, input kind_e k, input int val, input int st,
                       input int bal, input bit ev, input int ec, input bit done);
        vec_t v;
        v.card = card; v.kind = k; v.val = val; v.st = st;
        v.bal = bal; v.ev = ev; v.ec = ec; v.done = done;
        tbl.push_back(v);
    endtask

    task automatic clr();
        bus.pin_valid = 1'b0; bus.mode_valid = 1'b0; bus.amt_valid = 1'b0;
        bus.face_ok = 1'b0; bus.face_fail = 1'b0; bus.confirm = 1'b0; bus.cancel = 1'b0;
        bus.pin_data = '0; bus.mode = 1'b0; bus.amount = '0;
    endtask

    task automatic strobe(input kind_e k, input int val);
        clr();
        case (k)
            K_PIN:   begin bus.pin_valid = 1'b1; bus.pin_data = PIN_W'(val); end
            K_MODE:  begin bus.mode_valid = 1'b1; bus.mode = val[0]; end
            K_AMT:   begin bus.amt_valid = 1'b1; bus.amount = AMT_W'(val); end
            K_FOK:   bus.face_ok = 1'b1;
            K_FFAIL: bus.face_fail = 1'b1;
            K_CONF:  bus.confirm = 1'b1;
            K_CANC:  bus.cancel = 1'b1;
            default: ;
        endcase
    endtask

    task automatic go(input kind_e k, input int val);
        strobe(k, val);
        tick();
        clr();
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        bus.card_in = 1'b0;
        clr();
        tick();
        reset = 1'b0;
    endtask

    // Behavioural model: idle time and lockout age are counted upward
    int m_st, m_bal, m_att, m_mode, m_amt, m_ec, m_idle, m_lock;
    bit m_done, m_ev;

    function automatic bit waiting(input int s);
        return s == S_PIN || s == S_MODE || s == S_AMOUNT || s == S_FACE || s == S_STMT;
    endfunction

    task automatic model_step();
        int nxt;
        bit acc;
        int a;
        m_done = 1'b0;
        m_ev = 1'b0;
        if (reset) begin
            m_st = S_IDLE; m_bal = 0; m_att = 0; m_mode = 0; m_amt = 0;
            m_ec = E_NONE; m_idle = 0; m_lock = 0;
            return;
        end
        nxt = m_st;
        acc = 1'b0;
        a = int'(bus.amount);
        if (m_st != S_IDLE && m_st != S_LOCKED && !bus.card_in) begin
            nxt = S_IDLE;
            if (m_st != S_STMT) begin m_ev = 1'b1; m_ec = E_CARD_OUT; end
        end else if (waiting(m_st) && m_idle + 1 >= int'(TIMEOUT_CYC)) begin
            nxt = S_IDLE; m_ev = 1'b1; m_ec = E_TIMEOUT;
        end else begin
            case (m_st)
                S_IDLE: if (bus.card_in) begin
                    nxt = S_PIN; m_bal = int'(bus.bal_in); m_att = MAX_ATTEMPTS; m_ec = E_NONE;
                end
                S_PIN: if (bus.pin_valid) begin
                    acc = 1'b1;
                    if (bus.pin_data == bus.ref_pin) nxt = S_MODE;
                    else begin
                        m_att = m_att - 1;
                        m_ev = 1'b1;
                        if (m_att == 0) begin nxt = S_LOCKED; m_ec = E_LOCKED; end
                        else m_ec = E_BAD_PIN;
                    end
                end
                S_MODE: if (bus.mode_valid) begin
                    acc = 1'b1; m_mode = int'(bus.mode); nxt = S_AMOUNT;
                end
                S_AMOUNT: if (bus.amt_valid && a != 0) begin
                    acc = 1'b1;
                    m_amt = a;
                    nxt = S_COMMIT;
                    if (m_mode == 0) begin
                        if (a > m_bal) begin nxt = S_MODE; m_ev = 1'b1; m_ec = E_INSUFF; end
                        else if (a > int'(WD_LIMIT)) begin
`ifdef ATM_FACE_AUTH_EN
                            nxt = S_FACE;
`else
                            nxt = S_MODE; m_ev = 1'b1; m_ec = E_LIMIT;
`endif
                        end
                    end else if (a > int'(DEP_MAX)) begin
                        nxt = S_MODE; m_ev = 1'b1; m_ec = E_LIMIT;
                    end else if (m_bal + a >= (1 << BAL_W)) begin
                        nxt = S_MODE; m_ev = 1'b1; m_ec = E_OVERFLOW;
                    end
                end
                S_FACE: begin
                    if (bus.face_ok) begin acc = 1'b1; nxt = S_COMMIT; end
                    else if (bus.face_fail) begin acc = 1'b1; nxt = S_AMOUNT; end
                end
                S_COMMIT: begin
                    m_bal = (m_mode == 1) ? m_bal + m_amt : m_bal - m_amt;
                    m_done = 1'b1;
                    nxt = S_STMT;
                end
                S_STMT: begin
                    if (bus.confirm) begin acc = 1'b1; nxt = S_MODE; end
                    else if (bus.cancel) begin acc = 1'b1; nxt = S_IDLE; end
                end
                S_LOCKED: begin
                    m_lock++;
                    if (m_lock >= int'(LOCK_CYC) && !bus.card_in) nxt = S_IDLE;
                end
                default: ;
            endcase
        end
        if (nxt == S_LOCKED && m_st != S_LOCKED) m_lock = 0;
        if (nxt != m_st || acc) m_idle = 0;
        else m_idle++;
        m_st = nxt;
    endtask

    task automatic compare_model();
        chk("rnd state", int'(bus.state_o), m_st);
        chk("rnd balance", int'(bus.balance_o), m_bal);
        chk("rnd attempts", int'(bus.attempts_left), m_att);
        chk("rnd pin_locked", int'(bus.pin_locked), int'(m_st == S_LOCKED));
        chk("rnd txn_done", int'(bus.txn_done), int'(m_done));
        chk("rnd err_valid", int'(bus.err_valid), int'(m_ev));
        chk("rnd err_code", int'(bus.err_code), m_ec);
    endtask

    task automatic lock_card();
        bus.card_in = 1'b1;
        tick();
        chk("lock insert state", int'(bus.state_o), S_PIN);
        chk("lock insert attempts", int'(bus.attempts_left), 3);
        go(K_PIN, 2);
        chk("bad pin1 code", int'(bus.err_code), E_BAD_PIN);
        chk("bad pin1 valid", int'(bus.err_valid), 1);
        chk("bad pin1 attempts", int'(bus.attempts_left), 2);
        go(K_PIN, 3);
        chk("bad pin2 code", int'(bus.err_code), E_BAD_PIN);
        chk("bad pin2 attempts", int'(bus.attempts_left), 1);
        chk("bad pin2 state", int'(bus.state_o), S_PIN);
        go(K_PIN, 4);
        chk("lock state", int'(bus.state_o), S_LOCKED);
        chk("lock code", int'(bus.err_code), E_LOCKED);
        chk("lock valid", int'(bus.err_valid), 1);
        chk("lock attempts", int'(bus.attempts_left), 0);
        chk("lock pin_locked", int'(bus.pin_locked), 1);
    endtask

    task automatic to_amount(input int md);
        bus.card_in = 1'b1;
        tick();
        go(K_PIN, 1);
        go(K_MODE, md);
    endtask

    initial begin
        int fb, fe;
        string nm;
        reset = 1'b1;
        bus.card_in = 1'b0;
        bus.ref_pin = 4'd1;
        bus.bal_in = 16'd14;
        clr();
        tick();
        tick();
        chk("reset state", int'(bus.state_o), S_IDLE);
        chk("reset balance", int'(bus.balance_o), 0);
        chk("reset attempts", int'(bus.attempts_left), 0);
        chk("reset pin_locked", int'(bus.pin_locked), 0);
        chk("reset err_code", int'(bus.err_code), 0);
        reset = 1'b0;

        // Table: ref_pin 1, bal_in 14
        add(1, K_NONE, 0,  S_PIN,    14, 0, E_NONE,  0);
        add(1, K_PIN,  1,  S_MODE,   14, 0, E_NONE,  0);
        add(1, K_MODE, 0,  S_AMOUNT, 14, 0, E_NONE,  0);
        add(1, K_AMT,  0,  S_AMOUNT, 14, 0, E_NONE,  0);
        add(1, K_AMT,  20, S_MODE,   14, 1, E_INSUFF, 0);
        add(1, K_MODE, 1,  S_AMOUNT, 14, 0, E_INSUFF, 0);
        add(1, K_AMT,  11, S_MODE,   14, 1, E_LIMIT, 0);
        add(1, K_MODE, 0,  S_AMOUNT, 14, 0, E_LIMIT, 0);
        add(1, K_AMT,  5,  S_COMMIT, 14, 0, E_LIMIT, 0);
        add(1, K_NONE, 0,  S_STMT,   9,  0, E_LIMIT, 1);
        add(1, K_CONF, 0,  S_MODE,   9,  0, E_LIMIT, 0);
        add(1, K_MODE, 1,  S_AMOUNT, 9,  0, E_LIMIT, 0);
        add(1, K_AMT,  10, S_COMMIT, 9,  0, E_LIMIT, 0);
        add(1, K_NONE, 0,  S_STMT,   19, 0, E_LIMIT, 1);
        add(1, K_CANC, 0,  S_IDLE,   19, 0, E_LIMIT, 0);
        add(0, K_NONE, 0,  S_IDLE,   19, 0, E_LIMIT, 0);
        add(1, K_NONE, 0,  S_PIN,    14, 0, E_NONE,  0);
        add(1, K_PIN,  1,  S_MODE,   14, 0, E_NONE,  0);
        add(1, K_MODE, 0,  S_AMOUNT, 14, 0, E_NONE,  0);
`ifdef ATM_FACE_AUTH_EN
        fb = 2; fe = E_NONE;
        add(1, K_AMT,  12, S_FACE,   14, 0, E_NONE,  0);
        add(1, K_FFAIL, 0, S_AMOUNT, 14, 0, E_NONE,  0);
        add(1, K_AMT,  12, S_FACE,   14, 0, E_NONE,  0);
        add(1, K_FOK,  0,  S_COMMIT, 14, 0, E_NONE,  0);
        add(1, K_NONE, 0,  S_STMT,   2,  0, E_NONE,  1);
        add(1, K_CONF, 0,  S_MODE,   2,  0, E_NONE,  0);
        add(1, K_MODE, 0,  S_AMOUNT, 2,  0, E_NONE,  0);
`else
        fb = 14; fe = E_LIMIT;
        add(1, K_AMT,  12, S_MODE,   14, 1, E_LIMIT, 0);
        add(1, K_MODE, 0,  S_AMOUNT, 14, 0, E_LIMIT, 0);
`endif
        add(1, K_CONF, 0,  S_AMOUNT, fb, 0, fe,      0);
        add(0, K_NONE, 0,  S_IDLE,   fb, 1, E_CARD_OUT, 0);
        add(1, K_NONE, 0,  S_PIN,    14, 0, E_NONE,  0);
        add(1, K_PIN,  2,  S_PIN,    14, 1, E_BAD_PIN, 0);
        add(1, K_PIN,  1,  S_MODE,   14, 0, E_BAD_PIN, 0);
        add(1, K_MODE, 0,  S_AMOUNT, 14, 0, E_BAD_PIN, 0);
        add(1, K_AMT,  10, S_COMMIT, 14, 0, E_BAD_PIN, 0);
        add(1, K_NONE, 0,  S_STMT,   4,  0, E_BAD_PIN, 1);
        add(0, K_CONF, 0,  S_IDLE,   4,  0, E_BAD_PIN, 0);

        foreach (tbl[i]) begin
            bus.card_in = tbl[i].card;
            strobe(tbl[i].kind, tbl[i].val);
            tick();
            clr();
            nm = $sformatf("vec%0d", i);
            chk({nm, " state"}, int'(bus.state_o), tbl[i].st);
            chk({nm, " balance"}, int'(bus.balance_o), tbl[i].bal);
            chk({nm, " err_valid"}, int'(bus.err_valid), int'(tbl[i].ev));
            chk({nm, " err_code"}, int'(bus.err_code), tbl[i].ec);
            chk({nm, " txn_done"}, int'(bus.txn_done), int'(tbl[i].done));
        end

        // Lockout with card held well past LOCK_CYC, then removed
        reset_dut();
        lock_card();
        for (int i = 0; i < 70; i++) begin
            strobe(K_PIN, 1);
            bus.confirm = 1'b1;
            tick();
            chk("locked held state", int'(bus.state_o), S_LOCKED);
        end
        clr();
        bus.card_in = 1'b0;
        tick();
        chk("unlock state", int'(bus.state_o), S_IDLE);
        chk("unlock pin_locked", int'(bus.pin_locked), 0);
        chk("unlock err_valid", int'(bus.err_valid), 0);
        chk("unlock err_code", int'(bus.err_code), E_LOCKED);

        // Lockout with card removed immediately: exit exactly LOCK_CYC edges later
        lock_card();
        bus.card_in = 1'b0;
        for (int i = 1; i < int'(LOCK_CYC); i++) begin
            tick();
            chk($sformatf("lock wait %0d", i), int'(bus.state_o), S_LOCKED);
        end
        tick();
        chk("lock expiry state", int'(bus.state_o), S_IDLE);

        // INSUFF then idle timeout
        reset_dut();
        to_amount(0);
        go(K_AMT, 20);
        chk("insuff state", int'(bus.state_o), S_MODE);
        chk("insuff code", int'(bus.err_code), E_INSUFF);
        for (int i = 1; i < int'(TIMEOUT_CYC); i++) begin
            tick();
            chk($sformatf("idle wait %0d", i), int'(bus.state_o), S_MODE);
        end
        tick();
        chk("timeout state", int'(bus.state_o), S_IDLE);
        chk("timeout valid", int'(bus.err_valid), 1);
        chk("timeout code", int'(bus.err_code), E_TIMEOUT);

        // Deposit overflow boundary
        bus.bal_in = 16'd65530;
        to_amount(1);
        go(K_AMT, 10);
        chk("overflow state", int'(bus.state_o), S_MODE);
        chk("overflow code", int'(bus.err_code), E_OVERFLOW);
        chk("overflow balance", int'(bus.balance_o), 65530);
        go(K_MODE, 1);
        go(K_AMT, 5);
        chk("full deposit state", int'(bus.state_o), S_COMMIT);
        tick();
        chk("full deposit balance", int'(bus.balance_o), 65535);
        chk("full deposit done", int'(bus.txn_done), 1);

        // Reset while in COMMIT
        bus.bal_in = 16'd14;
        bus.card_in = 1'b0;
        tick();
        to_amount(0);
        go(K_AMT, 3);
        chk("pre-reset state", int'(bus.state_o), S_COMMIT);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid reset state", int'(bus.state_o), S_IDLE);
        chk("mid reset balance", int'(bus.balance_o), 0);
        chk("mid reset attempts", int'(bus.attempts_left), 0);
        chk("mid reset done", int'(bus.txn_done), 0);
        chk("mid reset err_valid", int'(bus.err_valid), 0);
        chk("mid reset err_code", int'(bus.err_code), 0);

        // Randomized traffic against the model
        reset = 1'b1;
        bus.card_in = 1'b0;
        clr();
        model_step();
        tick();
        compare_model();
        reset = 1'b0;
        for (int seg = 0; seg < 20; seg++) begin
            int p;
            int bsel;
            p = (seg % 2 == 1) ? 40 : 4;
            bus.ref_pin = PIN_W'($urandom_range(1, 2));
            bsel = $urandom_range(0, 3);
            case (bsel)
                0: bus.bal_in = 16'd14;
                1: bus.bal_in = BAL_W'(65525 + $urandom_range(0, 10));
                2: bus.bal_in = BAL_W'($urandom_range(0, 40));
                default: bus.bal_in = BAL_W'($urandom);
            endcase
            bus.card_in = 1'b1;
            for (int c = 0; c < 200; c++) begin
                reset = ($urandom_range(0, 999) == 0);
                if ($urandom_range(0, 99) < 2) bus.card_in = ~bus.card_in;
                bus.pin_valid  = ($urandom_range(0, 99) < p);
                bus.pin_data   = PIN_W'($urandom_range(0, 3));
                bus.mode_valid = ($urandom_range(0, 99) < p);
                bus.mode       = 1'($urandom_range(0, 1));
                bus.amt_valid  = ($urandom_range(0, 99) < p);
                bus.amount     = ($urandom_range(0, 3) == 0) ? AMT_W'($urandom)
                                                             : AMT_W'($urandom_range(0, 25));
                bus.face_ok    = ($urandom_range(0, 199) < p);
                bus.face_fail  = ($urandom_range(0, 199) < p);
                bus.confirm    = ($urandom_range(0, 199) < p);
                bus.cancel     = ($urandom_range(0, 199) < p);
                model_step();
                tick();
                compare_model();
            end
        end
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
